// File: rtl/uart_frame_tx_pkg.sv
// Shared UART definitions: parity codes, transmitter FSM states and a parity helper.
// The receive side imports the same package so both ends agree on frame format.
package uart_frame_tx_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Upper bits of narrower words are zero-padded, which does not change the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_frame_tx_fifo.sv
// First-word-fall-through synchronous FIFO with full flag and fill level.
// When full, a push is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_full    = (r_count == FULL_CNT);
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_level = r_count;

endmodule

// File: rtl/uart_frame_tx.sv
// UART transmitter: FIFO-fed start/data/parity/stop framer, LSB first, idle-high line.
// Back-to-back frames start directly from the last stop cycle with no idle gap.
module uart_frame_tx
    import uart_frame_tx_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          SystemClk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    input  logic                          clr_ovf,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          TX
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;

    if (PARITY < 0 || PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2) || DIV < 2 ||
        DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_cfg
        $error("uart_frame_tx: illegal parameter combination");
    end

    tx_state_t            r_state;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_overflow;

    logic [DATA_BITS-1:0] w_head;
    logic                 w_full;
    logic [LW-1:0]        w_level;
    logic                 w_bit_end;
    logic                 w_last_stop;
    logic                 w_pop;

    assign w_bit_end   = (r_cnt == CW'(DIV - 1));
    assign w_last_stop = (r_state == ST_STOP) && w_bit_end && (r_bit_idx == 4'(STOP_BITS - 1));
    assign w_pop       = (w_level != '0) && ((r_state == ST_IDLE) || w_last_stop);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (SystemClk),
        .i_reset (reset),
        .i_push  (wr_en),
        .i_data  (wr_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_level (w_level)
    );

    // A write while full is only lost when no pop frees a slot in the same cycle.
    always_ff @(posedge SystemClk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= (r_overflow & ~clr_ovf) | (wr_en & w_full & ~w_pop);
        end
    end

    always_ff @(posedge SystemClk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_cnt  <= w_bit_end ? '0 : r_cnt + CW'(1);
            case (r_state)
                ST_IDLE: begin
                    r_cnt  <= '0;
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_par   <= parity_bit(9'(w_head), PARITY);
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 4'(DATA_BITS - 1)) begin
                            r_bit_idx <= '0;
                            if (PARITY != PARITY_NONE) begin
                                r_tx    <= r_par;
                                r_state <= ST_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_bit_idx <= '0;
                        r_tx      <= 1'b1;
                        r_state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_last_stop) begin
                        r_done <= 1'b1;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_par   <= parity_bit(9'(w_head), PARITY);
                            r_tx    <= 1'b0;
                            r_state <= ST_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else if (w_bit_end) begin
                        r_bit_idx <= r_bit_idx + 4'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign full       = w_full;
    assign level      = w_level;
    assign overflow   = r_overflow;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign TX         = r_tx;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: frame shapes, parity, two stop bits, FIFO overflow,
// mid-frame reset and the minimum divider, with expected frames written out by hand.
module tb_uart_frame_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clr_ovf = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [4:0] wr_en = '0;
    logic [4:0] tx_w, busy_w, done_w, full_w, ovf_w;
    logic [4:0] lv0, lv1, lv2, lv3, lv4;

    int checks = 0;
    int failures = 0;
    int done_cnt;

    always #5 clk = ~clk;

    // 0: 8N1 DIV=16, 1: even parity, 2: odd parity, 3: two stop bits, 4: DIV=2
    uart_frame_tx #(.CLK_FREQ(16), .BAUD(1)) u0 (
        .SystemClk(clk), .reset(reset), .wr_en(wr_en[0]), .wr_data(wr_data),
        .full(full_w[0]), .level(lv0), .overflow(ovf_w[0]), .clr_ovf(clr_ovf),
        .busy(busy_w[0]), .frame_done(done_w[0]), .TX(tx_w[0]));
    uart_frame_tx #(.CLK_FREQ(16), .BAUD(1), .PARITY(2)) u1 (
        .SystemClk(clk), .reset(reset), .wr_en(wr_en[1]), .wr_data(wr_data),
        .full(full_w[1]), .level(lv1), .overflow(ovf_w[1]), .clr_ovf(clr_ovf),
        .busy(busy_w[1]), .frame_done(done_w[1]), .TX(tx_w[1]));
    uart_frame_tx #(.CLK_FREQ(16), .BAUD(1), .PARITY(1)) u2 (
        .SystemClk(clk), .reset(reset), .wr_en(wr_en[2]), .wr_data(wr_data),
        .full(full_w[2]), .level(lv2), .overflow(ovf_w[2]), .clr_ovf(clr_ovf),
        .busy(busy_w[2]), .frame_done(done_w[2]), .TX(tx_w[2]));
    uart_frame_tx #(.CLK_FREQ(16), .BAUD(1), .STOP_BITS(2)) u3 (
        .SystemClk(clk), .reset(reset), .wr_en(wr_en[3]), .wr_data(wr_data),
        .full(full_w[3]), .level(lv3), .overflow(ovf_w[3]), .clr_ovf(clr_ovf),
        .busy(busy_w[3]), .frame_done(done_w[3]), .TX(tx_w[3]));
    uart_frame_tx #(.CLK_FREQ(4), .BAUD(2)) u4 (
        .SystemClk(clk), .reset(reset), .wr_en(wr_en[4]), .wr_data(wr_data),
        .full(full_w[4]), .level(lv4), .overflow(ovf_w[4]), .clr_ovf(clr_ovf),
        .busy(busy_w[4]), .frame_done(done_w[4]), .TX(tx_w[4]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called in the first cycle of a start bit; returns in the cycle after the last stop bit.
    task automatic check_frame(input int id, input logic [15:0] bits, input int nbits,
                               input int div, input string tag);
        for (int i = 0; i < nbits * div; i++) begin
            chk({tag, "_tx"}, 32'(tx_w[id]), 32'(bits[i / div]));
            chk({tag, "_busy"}, 32'(busy_w[id]), 32'd1);
            if (i > 0) chk({tag, "_done_early"}, 32'(done_w[id]), 32'd0);
            step();
        end
        chk({tag, "_done"}, 32'(done_w[id]), 32'd1);
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        chk("rst_tx", 32'(tx_w), 32'h1f);
        chk("rst_busy", 32'(busy_w), 32'h0);
        chk("rst_done", 32'(done_w), 32'h0);
        chk("rst_full", 32'(full_w), 32'h0);
        chk("rst_ovf", 32'(ovf_w), 32'h0);
        chk("rst_level", 32'(lv0), 32'd0);

        // 8N1 0x12: 0,0,1,0,0,1,0,0,0,1
        wr_data = 8'h12; wr_en[0] = 1'b1;
        step();
        wr_en[0] = 1'b0;
        chk("lat_level", 32'(lv0), 32'd1);
        chk("lat_tx_idle", 32'(tx_w[0]), 32'd1);
        step();
        check_frame(0, 16'h0224, 10, 16, "f12");
        chk("f12_busy_end", 32'(busy_w[0]), 32'd0);
        chk("f12_tx_end", 32'(tx_w[0]), 32'd1);
        step();
        chk("f12_done_pulse", 32'(done_w[0]), 32'd0);

        // 0x0C has two ones: even parity bit 0, odd parity bit 1
        wr_data = 8'h0C; wr_en[1] = 1'b1;
        step();
        wr_en[1] = 1'b0;
        step();
        check_frame(1, 16'h0418, 11, 16, "even");
        chk("even_busy_end", 32'(busy_w[1]), 32'd0);
        wr_en[2] = 1'b1;
        step();
        wr_en[2] = 1'b0;
        step();
        check_frame(2, 16'h0618, 11, 16, "odd");
        chk("odd_busy_end", 32'(busy_w[2]), 32'd0);

        // Two stop bits, back-to-back frames with no idle gap
        wr_data = 8'hA5; wr_en[3] = 1'b1;
        step();
        wr_data = 8'h3C;
        step();
        wr_en[3] = 1'b0;
        check_frame(3, 16'h074A, 11, 16, "s2a");
        chk("s2_busy_gap", 32'(busy_w[3]), 32'd1);
        check_frame(3, 16'h0678, 11, 16, "s2b");
        chk("s2_busy_end", 32'(busy_w[3]), 32'd0);

        // Minimum divider
        wr_data = 8'hFF; wr_en[4] = 1'b1;
        step();
        wr_en[4] = 1'b0;
        step();
        check_frame(4, 16'h03FE, 10, 2, "div2");
        chk("div2_busy_end", 32'(busy_w[4]), 32'd0);

        // 18 consecutive pushes: first pops, 16 queue, 18th dropped
        wr_en[0] = 1'b1;
        for (int k = 0; k < 18; k++) begin
            wr_data = 8'(k + 1);
            step();
            if (k == 16) begin
                chk("ovf_full16", 32'(full_w[0]), 32'd1);
                chk("ovf_level16", 32'(lv0), 32'd16);
                chk("ovf_not_yet", 32'(ovf_w[0]), 32'd0);
            end
        end
        wr_en[0] = 1'b0;
        chk("ovf_set", 32'(ovf_w[0]), 32'd1);
        chk("ovf_level", 32'(lv0), 32'd16);
        clr_ovf = 1'b1;
        step();
        chk("ovf_clr", 32'(ovf_w[0]), 32'd0);
        wr_en[0] = 1'b1;
        step();
        wr_en[0] = 1'b0;
        clr_ovf = 1'b0;
        chk("ovf_set_beats_clr", 32'(ovf_w[0]), 32'd1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_clr2", 32'(ovf_w[0]), 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 2800; c++) begin
            if (done_w[0]) done_cnt++;
            step();
        end
        chk("ovf_frames", 32'(done_cnt), 32'd17);
        chk("ovf_drained_level", 32'(lv0), 32'd0);
        chk("ovf_drained_busy", 32'(busy_w[0]), 32'd0);

        // Reset in cycle 70 of a frame with one word still queued
        wr_data = 8'h12; wr_en[0] = 1'b1;
        step();
        wr_data = 8'h34;
        step();
        wr_en[0] = 1'b0;
        chk("mid_level_before", 32'(lv0), 32'd1);
        for (int c = 0; c < 70; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_tx", 32'(tx_w[0]), 32'd1);
        chk("mid_busy", 32'(busy_w[0]), 32'd0);
        chk("mid_level", 32'(lv0), 32'd0);
        step();
        chk("mid_stay_idle", 32'(tx_w[0]), 32'd1);
        wr_data = 8'h5A; wr_en[0] = 1'b1;
        step();
        wr_en[0] = 1'b0;
        step();
        check_frame(0, 16'h02B4, 10, 16, "after_rst");
        chk("after_rst_busy", 32'(busy_w[0]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
